// File: rtl/lock_pkg.sv
// Shared types for the keypad code lock: controller states, programming stages
// and the code-width helper.
package lock_pkg;

  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    EVAL    = 2'd1,
    OPEN    = 2'd2,
    LOCKOUT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    STG_UNLOCK = 2'd0,
    STG_AUTH   = 2'd1,
    STG_NEW    = 2'd2,
    STG_CONF   = 2'd3
  } stage_e;

  function automatic int unsigned code_w(input int unsigned len, input int unsigned w);
    return len * w;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the unlock hold and the failure lockout;
// done fires combinationally in the cycle the count steps 1 -> 0.
module lock_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         clr_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_c_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done_c_o = (cnt_q == W'(1)) && !load_i && !clr_i;

endmodule

// File: rtl/code_lock_core.sv
// Keypad code lock: digit entry, code compare, master-authorised reprogramming,
// failure lockout and timed auto-relock.
module code_lock_core
  import lock_pkg::*;
#(
  parameter int unsigned CODE_LEN    = 6,
  parameter int unsigned DIGIT_W     = 4,
  parameter int unsigned KEY_MODE    = 8,
  parameter int unsigned KEY_CLEAR   = 9,
  parameter logic [code_w(CODE_LEN, DIGIT_W)-1:0] DEFAULT_UC  = 24'h123456,
  parameter logic [code_w(CODE_LEN, DIGIT_W)-1:0] MASTER_CODE = 24'h777777,
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned LOCKOUT_CYC = 36000000,
  parameter int unsigned UNLOCK_CYC  = 60000000
) (
  input  logic                            hwclk,
  input  logic                            reset,
  input  logic                            key_valid,
  input  logic [DIGIT_W-1:0]              key_code,
  output logic [1:0]                      stage,
  output logic [$clog2(CODE_LEN+1)-1:0]   digit_count,
  output logic                            unlocked,
  output logic                            locked_out,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_count,
  output logic                            result_valid,
  output logic                            result_ok,
  output logic                            code_updated
);

  localparam int unsigned CODE_W  = code_w(CODE_LEN, DIGIT_W);
  localparam int unsigned CNT_W   = $clog2(CODE_LEN + 1);
  localparam int unsigned FAIL_W  = $clog2(MAX_FAIL + 1);
  localparam int unsigned TMR_MAX = (LOCKOUT_CYC > UNLOCK_CYC) ? LOCKOUT_CYC : UNLOCK_CYC;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  state_e              state_q, state_d;
  stage_e              stage_q, stage_d;
  logic [CODE_W-1:0]   buf_q, buf_d;
  logic [CODE_W-1:0]   uc_q, uc_d;
  logic [CODE_W-1:0]   cand_q, cand_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [FAIL_W-1:0]   fail_q, fail_d;
  logic                unlocked_q, unlocked_d;
  logic                locked_q, locked_d;
  logic                pend_v_q, pend_v_d;
  logic                pend_ok_q, pend_ok_d;
  logic                pend_cu_q, pend_cu_d;
  logic                rv_q, rok_q, cu_q;

  logic                is_mode_c, is_clear_c, is_digit_c, last_digit_c;
  logic                match_c, wrong_c, trip_c;
  logic [FAIL_W-1:0]   fail_inc_c;
  logic                tmr_load, tmr_clr, tmr_done_c;
  logic [TMR_W-1:0]    tmr_val;

  assign is_mode_c    = (key_code == DIGIT_W'(KEY_MODE));
  assign is_clear_c   = (key_code == DIGIT_W'(KEY_CLEAR));
  assign is_digit_c   = !is_mode_c && !is_clear_c;
  assign last_digit_c = (cnt_q == CNT_W'(CODE_LEN - 1));
  assign fail_inc_c   = (fail_q == FAIL_W'(MAX_FAIL)) ? fail_q : fail_q + FAIL_W'(1);
  assign wrong_c      = ((stage_q == STG_UNLOCK) || (stage_q == STG_AUTH)) && !match_c;
  assign trip_c       = wrong_c && (fail_inc_c == FAIL_W'(MAX_FAIL));

  // Target selection for the compare made in EVAL
  always_comb begin
    match_c = 1'b0;
    case (stage_q)
      STG_UNLOCK: match_c = (buf_q == uc_q);
      STG_AUTH:   match_c = (buf_q == MASTER_CODE);
      STG_CONF:   match_c = (buf_q == cand_q);
      default:    match_c = 1'b0;
    endcase
  end

  always_ff @(posedge hwclk) begin
    if (reset) begin
      state_q    <= ENTRY;
      stage_q    <= STG_UNLOCK;
      buf_q      <= '0;
      uc_q       <= DEFAULT_UC;
      cand_q     <= '0;
      cnt_q      <= '0;
      fail_q     <= '0;
      unlocked_q <= 1'b0;
      locked_q   <= 1'b0;
      pend_v_q   <= 1'b0;
      pend_ok_q  <= 1'b0;
      pend_cu_q  <= 1'b0;
      rv_q       <= 1'b0;
      rok_q      <= 1'b0;
      cu_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      buf_q      <= buf_d;
      uc_q       <= uc_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      fail_q     <= fail_d;
      unlocked_q <= unlocked_d;
      locked_q   <= locked_d;
      pend_v_q   <= pend_v_d;
      pend_ok_q  <= pend_ok_d;
      pend_cu_q  <= pend_cu_d;
      rv_q       <= pend_v_q;
      rok_q      <= pend_ok_q;
      cu_q       <= pend_cu_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ENTRY:   if (key_valid && is_digit_c && last_digit_c) state_d = EVAL;
      EVAL: begin
        if ((stage_q == STG_UNLOCK) && match_c) state_d = OPEN;
        else if (trip_c)                        state_d = LOCKOUT;
        else                                    state_d = ENTRY;
      end
      OPEN:    if ((key_valid && is_clear_c) || tmr_done_c) state_d = ENTRY;
      LOCKOUT: if (tmr_done_c) state_d = ENTRY;
      default: state_d = ENTRY;
    endcase
  end

  // Datapath and status next values
  always_comb begin
    stage_d    = stage_q;
    buf_d      = buf_q;
    uc_d       = uc_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    fail_d     = fail_q;
    unlocked_d = unlocked_q;
    locked_d   = locked_q;
    pend_v_d   = 1'b0;
    pend_ok_d  = 1'b0;
    pend_cu_d  = 1'b0;
    tmr_load   = 1'b0;
    tmr_clr    = 1'b0;
    tmr_val    = '0;
    case (state_q)
      ENTRY: begin
        if (key_valid) begin
          if (is_digit_c) begin
            buf_d = (buf_q << DIGIT_W) | CODE_W'(key_code);
            cnt_d = cnt_q + CNT_W'(1);
          end else if (is_clear_c) begin
            buf_d = '0;
            cnt_d = '0;
            if ((stage_q == STG_NEW) || (stage_q == STG_CONF)) begin
              stage_d = STG_UNLOCK;
              cand_d  = '0;
            end
          end else if ((cnt_q == '0) && (stage_q == STG_UNLOCK)) begin
            stage_d = STG_AUTH;
          end else if ((cnt_q == '0) && (stage_q == STG_AUTH)) begin
            stage_d = STG_UNLOCK;
          end
        end
      end
      EVAL: begin
        buf_d    = '0;
        cnt_d    = '0;
        pend_v_d = 1'b0 | 1'b1;
        if (wrong_c) begin
          fail_d = fail_inc_c;
          if (trip_c) begin
            locked_d = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(LOCKOUT_CYC);
            stage_d  = STG_UNLOCK;
          end
        end else begin
          case (stage_q)
            STG_UNLOCK: begin
              unlocked_d = 1'b1;
              tmr_load   = 1'b1;
              tmr_val    = TMR_W'(UNLOCK_CYC);
              fail_d     = '0;
              pend_ok_d  = 1'b1;
            end
            STG_AUTH: begin
              stage_d   = STG_NEW;
              fail_d    = '0;
              pend_ok_d = 1'b1;
            end
            STG_NEW: begin
              cand_d    = buf_q;
              stage_d   = STG_CONF;
              pend_ok_d = 1'b1;
            end
            default: begin
              stage_d = STG_UNLOCK;
              cand_d  = '0;
              if (match_c) begin
                uc_d      = buf_q;
                pend_ok_d = 1'b1;
                pend_cu_d = 1'b1;
              end
            end
          endcase
        end
      end
      OPEN: begin
        if (key_valid && is_clear_c) begin
          unlocked_d = 1'b0;
          tmr_clr    = 1'b1;
        end else if (tmr_done_c) begin
          unlocked_d = 1'b0;
        end
      end
      LOCKOUT: begin
        if (tmr_done_c) begin
          locked_d = 1'b0;
          fail_d   = '0;
        end
      end
      default: ;
    endcase
  end

  lock_timer #(.W(TMR_W)) u_timer (
    .clk_i      (hwclk),
    .rst_i      (reset),
    .load_i     (tmr_load),
    .clr_i      (tmr_clr),
    .load_val_i (tmr_val),
    .done_c_o   (tmr_done_c)
  );

  assign stage        = stage_q;
  assign digit_count  = cnt_q;
  assign unlocked     = unlocked_q;
  assign locked_out   = locked_q;
  assign fail_count   = fail_q;
  assign result_valid = rv_q;
  assign result_ok    = rok_q;
  assign code_updated = cu_q;

endmodule

// File: tb/tb_code_lock_core.sv
// Directed bench for code_lock_core with short unlock/lockout timers.
module tb_code_lock_core;

  logic       hwclk;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic [1:0] stage;
  logic [2:0] digit_count;
  logic       unlocked;
  logic       locked_out;
  logic [1:0] fail_count;
  logic       result_valid;
  logic       result_ok;
  logic       code_updated;

  int n_cmp = 0;
  int n_err = 0;

  code_lock_core #(
    .UNLOCK_CYC  (8),
    .LOCKOUT_CYC (16)
  ) dut (
    .hwclk        (hwclk),
    .reset        (reset),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .stage        (stage),
    .digit_count  (digit_count),
    .unlocked     (unlocked),
    .locked_out   (locked_out),
    .fail_count   (fail_count),
    .result_valid (result_valid),
    .result_ok    (result_ok),
    .code_updated (code_updated)
  );

  initial hwclk = 1'b0;
  always #5 hwclk = ~hwclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the sampling edge.
  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge hwclk);
    key_valid = 1'b0;
    key_code  = 4'd0;
  endtask

  task automatic eval_code(input logic [23:0] code, input logic exp_ok, input string tag);
    logic [23:0] c;
    c = code;
    for (int i = 0; i < 6; i++) press(c[23-4*i -: 4]);
    @(negedge hwclk);
    check({tag, "_rv_early"}, 32'(result_valid), 0);
    @(negedge hwclk);
    check({tag, "_rv"}, 32'(result_valid), 1);
    check({tag, "_ok"}, 32'(result_ok), 32'(exp_ok));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_stage"}, 32'(stage), 0);
    check({tag, "_cnt"}, 32'(digit_count), 0);
    check({tag, "_unl"}, 32'(unlocked), 0);
    check({tag, "_lck"}, 32'(locked_out), 0);
    check({tag, "_fail"}, 32'(fail_count), 0);
    check({tag, "_rv"}, 32'(result_valid), 0);
    check({tag, "_ok"}, 32'(result_ok), 0);
    check({tag, "_cu"}, 32'(code_updated), 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge hwclk);
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'd0;
    @(negedge hwclk);
    @(negedge hwclk);
    check_reset_state("rst");
    reset = 1'b0;

    // unlock with default code, auto-relock after 8 cycles
    eval_code(24'h123456, 1'b1, "unlock");
    check("unlock_level", 32'(unlocked), 1);
    repeat (6) @(negedge hwclk);
    check("unlock_hold_last", 32'(unlocked), 1);
    @(negedge hwclk);
    check("unlock_relock", 32'(unlocked), 0);
    check("unlock_stage", 32'(stage), 0);

    // three wrong codes lead to lockout
    eval_code(24'h111111, 1'b0, "wrong1");
    check("wrong1_fail", 32'(fail_count), 1);
    eval_code(24'h111111, 1'b0, "wrong2");
    check("wrong2_fail", 32'(fail_count), 2);
    eval_code(24'h111111, 1'b0, "wrong3");
    check("lock_level", 32'(locked_out), 1);
    check("lock_fail_sat", 32'(fail_count), 3);
    for (int i = 1; i <= 6; i++) press(4'(i));
    check("lock_keys_ignored", 32'(digit_count), 0);
    press(4'd8);
    check("lock_mode_ignored", 32'(stage), 0);
    repeat (7) @(negedge hwclk);
    check("lock_hold_last", 32'(locked_out), 1);
    @(negedge hwclk);
    check("lock_release", 32'(locked_out), 0);
    check("lock_fail_clr", 32'(fail_count), 0);
    eval_code(24'h123456, 1'b1, "post_lock");
    press(4'd9);
    check("open_clear_relock", 32'(unlocked), 0);

    // clear and abort
    press(4'd1);
    press(4'd2);
    check("clr_cnt2", 32'(digit_count), 2);
    press(4'd9);
    check("clr_cnt0", 32'(digit_count), 0);
    press(4'd1);
    press(4'd8);
    check("mode_midentry_cnt", 32'(digit_count), 1);
    check("mode_midentry_stage", 32'(stage), 0);
    press(4'd9);
    press(4'd8);
    check("mode_stage1", 32'(stage), 1);
    eval_code(24'h777777, 1'b1, "abort_master");
    check("abort_stage2", 32'(stage), 2);
    press(4'd3);
    check("abort_cnt1", 32'(digit_count), 1);
    press(4'd9);
    check("abort_stage0", 32'(stage), 0);
    check("abort_cnt0", 32'(digit_count), 0);
    eval_code(24'h123456, 1'b1, "abort_code_kept");
    press(4'd9);

    // reprogram to 246135
    press(4'd8);
    check("prog_stage1", 32'(stage), 1);
    eval_code(24'h777777, 1'b1, "prog_master");
    check("prog_stage2", 32'(stage), 2);
    eval_code(24'h246135, 1'b1, "prog_new");
    check("prog_stage3", 32'(stage), 3);
    check("prog_cu_none", 32'(code_updated), 0);
    eval_code(24'h246135, 1'b1, "prog_conf");
    check("prog_cu", 32'(code_updated), 1);
    check("prog_stage0", 32'(stage), 0);
    @(negedge hwclk);
    check("prog_cu_once", 32'(code_updated), 0);
    eval_code(24'h123456, 1'b0, "old_code");
    check("old_code_fail", 32'(fail_count), 1);
    eval_code(24'h246135, 1'b1, "new_code");
    check("new_code_fail", 32'(fail_count), 0);
    check("new_code_unl", 32'(unlocked), 1);
    press(4'd9);

    // reset during stage 3 restores the default code
    press(4'd8);
    eval_code(24'h777777, 1'b1, "rst3_master");
    eval_code(24'h111222, 1'b1, "rst3_new");
    press(4'd1);
    press(4'd2);
    check("rst3_pre_stage", 32'(stage), 3);
    pulse_reset();
    check_reset_state("rst3");
    eval_code(24'h123456, 1'b1, "rst3_default");
    press(4'd9);

    // confirm mismatch leaves the code unchanged
    press(4'd8);
    eval_code(24'h777777, 1'b1, "mis_master");
    eval_code(24'h246135, 1'b1, "mis_new");
    eval_code(24'h246134, 1'b0, "mis_conf");
    check("mis_stage", 32'(stage), 0);
    check("mis_fail", 32'(fail_count), 0);
    check("mis_cu", 32'(code_updated), 0);
    eval_code(24'h123456, 1'b1, "mis_default");
    press(4'd9);

    // reset during lockout
    eval_code(24'h654321, 1'b0, "rstl_w1");
    eval_code(24'h654321, 1'b0, "rstl_w2");
    eval_code(24'h654321, 1'b0, "rstl_w3");
    check("rstl_locked", 32'(locked_out), 1);
    pulse_reset();
    check_reset_state("rstl");
    eval_code(24'h123456, 1'b1, "rstl_default");
    press(4'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/code_lock_core.md
Name: code_lock_core

Overview:
- Parametrised successor to the fixed 6-digit keypad lock: one block owns code entry, length check, comparison, code re-programming, failure lockout and unlock timing.
- Consumes debounced key events from the keypad scanner (one pulse per press); drives status levels and pulses to the LED/blinker logic in top.
- Adds over the current design: configurable length/width, master-authorised three-stage code change with confirmation, failure counting with timed lockout, timed auto-relock.

Parameters:
- CODE_LEN, 6, digits per code (>=1)
- DIGIT_W, 4, bits per key code
- KEY_MODE, 8, key value that toggles unlock/program mode
- KEY_CLEAR, 9, key value that discards entry / aborts
- DEFAULT_UC, 24'h123456, user code after reset (CODE_LEN*DIGIT_W bits, first digit in MSBs)
- MASTER_CODE, 24'h777777, fixed master code, not writable
- MAX_FAIL, 3, consecutive wrong codes that trigger lockout (>=1)
- LOCKOUT_CYC, 36000000, lockout duration in hwclk cycles
- UNLOCK_CYC, 60000000, unlock hold time in hwclk cycles

Ports:
- hwclk  in  1  system clock
- reset  in  1  synchronous, active-high
- key_valid  in  1  one-cycle pulse, key_code valid
- key_code  in  DIGIT_W  pressed key value
- stage  out  2  0=unlock entry, 1=master auth, 2=new code, 3=confirm
- digit_count  out  $clog2(CODE_LEN+1)  digits buffered
- unlocked  out  1  level, lock open
- locked_out  out  1  level, keys ignored
- fail_count  out  $clog2(MAX_FAIL+1)  consecutive failures
- result_valid  out  1  one-cycle pulse per evaluated code
- result_ok  out  1  qualifies result_valid
- code_updated  out  1  one-cycle pulse when the user code is rewritten

Behaviour:
- The clock and reset are decided: a single clock, hwclk; reset is synchronous and active-high.
- Reset: stage=0, digit_count=0, unlocked=0, locked_out=0, fail_count=0, result_valid=0, result_ok=0, code_updated=0, user code=DEFAULT_UC, timer=0. A reset mid-entry, mid-lockout or mid-programming discards everything, including any previously programmed code.
- States: ENTRY, EVAL, OPEN, LOCKOUT. The stage register qualifies ENTRY.
- ENTRY, digit key (neither KEY_MODE nor KEY_CLEAR): shift the digit into the buffer LSB side and increment digit_count. When the count reaches CODE_LEN, go to EVAL on the same edge.
- Latency: result_valid rises exactly 2 edges after the edge that sampled the final digit.
- EVAL: one cycle. Compare the buffer against the target: stage 0 uses the user code, stage 1 uses MASTER_CODE, stage 2 has no comparison, stage 3 uses the stage-2 latch. Clear the buffer and digit_count, then act by stage:
  - stage 0 ok: unlocked=1, load timer with UNLOCK_CYC, go to OPEN, fail_count=0.
  - stage 0/1 wrong: fail_count+1, result_ok=0. If the new fail_count equals MAX_FAIL: locked_out=1, load LOCKOUT_CYC, go to LOCKOUT, stage=0. Otherwise return to ENTRY with the same stage.
  - stage 1 ok: stage=2, fail_count=0.
  - stage 2: latch the buffer as the candidate code, stage=3. result_valid pulses with result_ok=1.
  - stage 3 match: write the user code, code_updated pulse, stage=0. Mismatch: stage=0, user code unchanged, result_ok=0, fail_count unchanged.
- KEY_MODE: acted on only in ENTRY with digit_count==0 and stage 0 or 1; toggles between those two stages. Ignored in all other cases.
- KEY_CLEAR:
  - ENTRY stage 0/1: clear the buffer.
  - ENTRY stage 2/3: abort programming and return to stage 0; the candidate is discarded.
  - OPEN: relock immediately (unlocked=0 on the next edge).
- OPEN: the timer decrements each cycle. At 1->0, unlocked=0 and go to ENTRY. Digit and mode keys are ignored.
- LOCKOUT: all keys ignored. At timer 1->0: locked_out=0, fail_count=0, go to ENTRY.
- Key arriving in the EVAL cycle: dropped.
- fail_count saturates at MAX_FAIL and never wraps.
- Timer width is $clog2(max(LOCKOUT_CYC,UNLOCK_CYC)+1).

Decomposition:
- Package lock_pkg: state enum (ENTRY, EVAL, OPEN, LOCKOUT), stage encodings (STG_UNLOCK, STG_AUTH, STG_NEW, STG_CONF), and a CODE_W = CODE_LEN*DIGIT_W helper function.
- One sub-module, lock_timer: loadable down-counter with a done pulse, shared by OPEN and LOCKOUT.

Test Plan:
Bench parameters: UNLOCK_CYC=8, LOCKOUT_CYC=16.
- Unlock: keys 1,2,3,4,5,6 -> result_valid 2 edges after the "6" edge with result_ok=1; unlocked high 8 cycles, then 0, stage=0.
- Lockout: 3x wrong code 111111 -> fail_count 1,2, then locked_out=1. Keys during lockout are ignored. After 16 cycles locked_out=0 and fail_count=0; then 123456 unlocks.
- Reprogram: 8, 777777, 246135, 246135 -> stage walks 1,2,3,0; code_updated pulses once. 123456 then fails and 246135 unlocks.
- Confirm mismatch: 8, 777777, 246135, 246134 -> result_ok=0, stage=0, fail_count=0; 123456 still unlocks.
- Clear/abort: 1,2,9 -> digit_count 0. In stage 2, 3,9 -> stage 0, code unchanged. In OPEN, 9 -> unlocked drops the next cycle.
- Reset mid-op: reset asserted during stage 3 or lockout -> all outputs at reset values next edge; a code written earlier reverts to 123456.
